// File: rtl/alu_op_sequencer_if.sv
// Bundle between the ALU op sequencer and its command source, register file, ALU and TX FIFO.
// master is the sequencer's view; slave is the surrounding environment's view.
interface alu_op_sequencer_if #(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned ADDR_SIZE = 4
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [3:0]             cmd_fun;
  logic                   cmd_use_ops;
  logic [D_WIDTH-1:0]     cmd_op_a;
  logic [D_WIDTH-1:0]     cmd_op_b;

  logic                   Wr_En;
  logic [ADDR_SIZE-1:0]   Addr;
  logic [D_WIDTH-1:0]     Wr_D;

  logic                   Gate_En;
  logic                   ALU_En;
  logic [3:0]             ALU_FUN;
  logic [2*D_WIDTH-1:0]   ALU_OUT;
  logic                   OUT_Valid;

  logic                   FIFO_FULL;
  logic                   WR_INC;
  logic [D_WIDTH-1:0]     WR_DATA;

  logic                   busy;
  logic                   timeout_err;

  modport master (
    input  cmd_valid, cmd_fun, cmd_use_ops, cmd_op_a, cmd_op_b, ALU_OUT, OUT_Valid, FIFO_FULL,
    output cmd_ready, Wr_En, Addr, Wr_D, Gate_En, ALU_En, ALU_FUN, WR_INC, WR_DATA, busy,
           timeout_err
  );

  modport slave (
    output cmd_valid, cmd_fun, cmd_use_ops, cmd_op_a, cmd_op_b, ALU_OUT, OUT_Valid, FIFO_FULL,
    input  cmd_ready, Wr_En, Addr, Wr_D, Gate_En, ALU_En, ALU_FUN, WR_INC, WR_DATA, busy,
           timeout_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Runs one ALU command: optional operand writes, gated-clock fire, result capture with timeout,
// then drains the 16-bit result to the TX FIFO as two bytes, LSB first.
module alu_op_sequencer #(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned OPA_ADDR  = 0,
  parameter int unsigned OPB_ADDR  = 1,
  parameter int unsigned TIMEOUT   = 15
) (
  input logic                CLK,
  input logic                RST,
  alu_op_sequencer_if.master bus
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StWrA, StWrB, StArm, StExec, StWaitRes, StPushLo, StPushHi
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             fun_q, fun_d;
  logic                   use_ops_q, use_ops_d;
  logic [D_WIDTH-1:0]     op_a_q, op_a_d;
  logic [D_WIDTH-1:0]     op_b_q, op_b_d;
  logic [2*D_WIDTH-1:0]   result_q, result_d;
  logic [7:0]             cnt_q, cnt_d;

  logic                   cmd_ready;
  logic                   wr_en;
  logic [ADDR_SIZE-1:0]   addr;
  logic [D_WIDTH-1:0]     wr_d;
  logic                   gate_en;
  logic                   alu_en;
  logic [3:0]             alu_fun;
  logic                   wr_inc;
  logic [D_WIDTH-1:0]     wr_data;
  logic                   timeout_err;

  always_comb begin
    state_d     = state_q;
    fun_d       = fun_q;
    use_ops_d   = use_ops_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    cmd_ready   = 1'b0;
    wr_en       = 1'b0;
    addr        = '0;
    wr_d        = '0;
    gate_en     = 1'b0;
    alu_en      = 1'b0;
    alu_fun     = '0;
    wr_inc      = 1'b0;
    wr_data     = '0;
    timeout_err = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          fun_d     = bus.cmd_fun;
          use_ops_d = bus.cmd_use_ops;
          op_a_d    = bus.cmd_op_a;
          op_b_d    = bus.cmd_op_b;
          state_d   = bus.cmd_use_ops ? StWrA : StArm;
        end
      end
      StWrA: begin
        wr_en   = 1'b1;
        addr    = ADDR_SIZE'(OPA_ADDR);
        wr_d    = op_a_q;
        state_d = StWrB;
      end
      StWrB: begin
        wr_en   = 1'b1;
        addr    = ADDR_SIZE'(OPB_ADDR);
        wr_d    = op_b_q;
        state_d = StArm;
      end
      StArm: begin
        // Gate opens a cycle early so the ALU clock is running when the fire pulse lands.
        gate_en = 1'b1;
        alu_fun = fun_q;
        state_d = StExec;
      end
      StExec: begin
        gate_en = 1'b1;
        alu_en  = 1'b1;
        alu_fun = fun_q;
        cnt_d   = '0;
        state_d = StWaitRes;
      end
      StWaitRes: begin
        gate_en = 1'b1;
        alu_fun = fun_q;
        cnt_d   = cnt_q + 8'd1;
        if (bus.OUT_Valid) begin
          result_d = bus.ALU_OUT;
          state_d  = StPushLo;
        end else if (cnt_d == TimeoutVal) begin
          timeout_err = 1'b1;
          state_d     = StIdle;
        end
      end
      StPushLo: begin
        wr_data = result_q[D_WIDTH-1:0];
        wr_inc  = !bus.FIFO_FULL;
        if (wr_inc) state_d = StPushHi;
      end
      StPushHi: begin
        wr_data = result_q[2*D_WIDTH-1:D_WIDTH];
        wr_inc  = !bus.FIFO_FULL;
        if (wr_inc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      fun_q     <= '0;
      use_ops_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fun_q     <= fun_d;
      use_ops_q <= use_ops_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  // While reset is held, present the idle face so no strobe escapes before the abort edge.
  assign bus.cmd_ready   = !RST || cmd_ready;
  assign bus.busy        = RST && (state_q != StIdle);
  assign bus.Wr_En       = RST && wr_en;
  assign bus.Addr        = RST ? addr : '0;
  assign bus.Wr_D        = RST ? wr_d : '0;
  assign bus.Gate_En     = RST && gate_en;
  assign bus.ALU_En      = RST && alu_en;
  assign bus.ALU_FUN     = RST ? alu_fun : '0;
  assign bus.WR_INC      = RST && wr_inc;
  assign bus.WR_DATA     = RST ? wr_data : '0;
  assign bus.timeout_err = RST && timeout_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus queues expected strobes with their cycle,
// a negedge monitor pops and compares every strobe the DUT produces.
module tb_alu_op_sequencer;
  localparam int KWrite   = 0;
  localparam int KFire    = 1;
  localparam int KPush    = 2;
  localparam int KTimeout = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic CLK;
  logic RST;
  int   cyc;
  int   n_checks;
  int   n_fail;
  ev_t  exp_q[$];

  logic [15:0] alu_val;
  bit          alu_respond;

  alu_op_sequencer_if #(.D_WIDTH(8), .ADDR_SIZE(4)) bus ();

  alu_op_sequencer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected strobe: actual kind %0d val %0h required none (cycle %0d)",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      check("strobe kind", kind, e.kind);
      check("strobe value", val, e.val);
      check("strobe cycle", cyc, e.cyc);
    end
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (bus.Wr_En) observe(KWrite, int'({bus.Addr, bus.Wr_D}));
    if (bus.ALU_En) begin
      check("gate on at fire", int'(bus.Gate_En), 1);
      observe(KFire, int'(bus.ALU_FUN));
    end
    if (bus.WR_INC) begin
      check("gate off while pushing", int'(bus.Gate_En), 0);
      observe(KPush, int'(bus.WR_DATA));
    end
    if (bus.timeout_err) observe(KTimeout, 0);
  end

  // ALU model: result valid for one cycle, one cycle after the fire pulse.
  initial begin
    bus.OUT_Valid = 1'b0;
    bus.ALU_OUT   = '0;
    forever begin
      @(negedge CLK);
      if (bus.ALU_En && alu_respond) begin
        @(posedge CLK);
        #1;
        bus.OUT_Valid = 1'b1;
        bus.ALU_OUT   = alu_val;
        @(posedge CLK);
        #1;
        bus.OUT_Valid = 1'b0;
        bus.ALU_OUT   = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog");
  end

  // Presents a command, returns accept cycle k, leaves time at period k+1 plus #1.
  task automatic issue(input logic [3:0] fun, input logic use_ops, input logic [7:0] a,
                       input logic [7:0] b, output int k);
    int t;
    @(posedge CLK);
    #1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_fun     = fun;
    bus.cmd_use_ops = use_ops;
    bus.cmd_op_a    = a;
    bus.cmd_op_b    = b;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!bus.cmd_ready && t < 100);
    check("command accepted", int'(bus.cmd_ready), 1);
    k = cyc;
    @(posedge CLK);
    #1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_fun     = ~fun;
    bus.cmd_use_ops = ~use_ops;
    bus.cmd_op_a    = ~a;
    bus.cmd_op_b    = ~b;
  endtask

  task automatic wait_ready(input string name, input int at);
    int t;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!bus.cmd_ready && t < 100);
    check(name, cyc, at);
  endtask

  task automatic run_cmd(input string name, input logic [3:0] fun, input logic use_ops,
                         input logic [7:0] a, input logic [7:0] b, input logic [15:0] res,
                         input bit respond, input int stall);
    int k;
    int off;
    int lo;
    int done;
    alu_val        = res;
    alu_respond    = respond;
    bus.FIFO_FULL  = (stall > 0);
    issue(fun, use_ops, a, b, k);
    off = use_ops ? 0 : -2;
    if (use_ops) begin
      expect_ev(KWrite, int'({4'd0, a}), k + 1);
      expect_ev(KWrite, int'({4'd1, b}), k + 2);
    end
    expect_ev(KFire, int'(fun), k + 4 + off);
    if (respond) begin
      lo = k + 6 + off + stall;
      expect_ev(KPush, int'(res[7:0]), lo);
      expect_ev(KPush, int'(res[15:8]), lo + 1);
      done = lo + 2;
      if (stall > 0) begin
        repeat (lo - (k + 1)) @(posedge CLK);
        #1;
        bus.FIFO_FULL = 1'b0;
      end
    end else begin
      expect_ev(KTimeout, 0, k + 5 + off + 14);
      done = k + 5 + off + 15;
    end
    wait_ready(name, done);
  endtask

  initial begin
    int k;
    n_checks        = 0;
    n_fail          = 0;
    alu_val         = '0;
    alu_respond     = 1'b0;
    RST             = 1'b0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_fun     = 4'h7;
    bus.cmd_use_ops = 1'b1;
    bus.cmd_op_a    = 8'h55;
    bus.cmd_op_b    = 8'hAA;
    bus.FIFO_FULL   = 1'b0;

    // Reset held with a pending command: idle face, nothing accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("reset cmd_ready", int'(bus.cmd_ready), 1);
      check("reset outputs zero", int'({bus.Wr_En, bus.Gate_En, bus.ALU_En, bus.WR_INC,
            bus.busy, bus.timeout_err, bus.Addr, bus.Wr_D, bus.ALU_FUN, bus.WR_DATA}), 0);
    end
    @(posedge CLK);
    #1;
    RST           = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge CLK);
    check("post-reset cmd_ready", int'(bus.cmd_ready), 1);
    check("post-reset busy", int'(bus.busy), 0);

    run_cmd("ready after full op", 4'd2, 1'b1, 8'h12, 8'h34, 16'h03A8, 1'b1, 0);
    run_cmd("ready after reuse op", 4'd0, 1'b0, 8'h00, 8'h00, 16'h00FF, 1'b1, 0);
    run_cmd("ready after stalled push", 4'd1, 1'b1, 8'h05, 8'h07, 16'hBEEF, 1'b1, 5);
    run_cmd("ready after timeout", 4'd3, 1'b1, 8'h09, 8'h03, 16'h0000, 1'b0, 0);
    check("gate off after timeout", int'(bus.Gate_En), 0);
    check("idle after timeout", int'(bus.busy), 0);

    // Reset while stalled in PUSH_LO: abort with no push.
    alu_val       = 16'h5566;
    alu_respond   = 1'b1;
    bus.FIFO_FULL = 1'b1;
    issue(4'd5, 1'b0, 8'h00, 8'h00, k);
    expect_ev(KFire, 5, k + 2);
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("no push under reset", int'(bus.WR_INC), 0);
    check("abort cycle is push_lo+1", cyc, k + 5);
    @(posedge CLK);
    #1;
    RST           = 1'b1;
    bus.FIFO_FULL = 1'b0;
    @(negedge CLK);
    check("idle after abort", int'(bus.busy), 0);
    check("ready after abort", int'(bus.cmd_ready), 1);
    repeat (5) @(negedge CLK);

    run_cmd("ready after post-abort op", 4'd4, 1'b0, 8'h00, 8'h00, 16'h1234, 1'b1, 0);

    repeat (5) @(negedge CLK);
    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequences one ALU operation end to end in the REF_CLK domain. It accepts a decoded command, optionally writes operands A/B into the register file, enables the ALU clock gate, fires the ALU, and captures the 16-bit result. It then pushes the result as two bytes (LSB first) into the async TX FIFO, honouring FIFO full. It sits between the frame-decoding system controller and the ALU / Reg_File / clock-gate / FIFO write port.

Parameters:
D_WIDTH, 8, operand and FIFO byte width; the ALU result is 2*D_WIDTH.
ADDR_SIZE, 4, register file address width.
OPA_ADDR, 0, register file address of operand A.
OPB_ADDR, 1, register file address of operand B.
TIMEOUT, 15, maximum number of WAIT_RES cycles to wait for OUT_Valid (1..255).

Ports:
CLK  in  1  REF_CLK domain clock.
RST  in  1  synchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
cmd_fun  in  4  ALU function code.
cmd_use_ops  in  1  1: write cmd_op_a/cmd_op_b before executing; 0: reuse the stored operands.
cmd_op_a  in  D_WIDTH  operand A.
cmd_op_b  in  D_WIDTH  operand B.
Wr_En  out  1  register file write strobe.
Addr  out  ADDR_SIZE  register file address.
Wr_D  out  D_WIDTH  register file write data.
Gate_En  out  1  ALU clock-gate enable.
ALU_En  out  1  one-cycle ALU fire pulse.
ALU_FUN  out  4  function code held during the operation.
ALU_OUT  in  2*D_WIDTH  ALU result.
OUT_Valid  in  1  ALU result valid.
FIFO_FULL  in  1  TX FIFO full.
WR_INC  out  1  FIFO write strobe.
WR_DATA  out  D_WIDTH  FIFO write data.
busy  out  1  high whenever the state is not IDLE.
timeout_err  out  1  one-cycle pulse on ALU timeout.

Behaviour:
- Reset (RST=0 at a CLK edge) forces IDLE and clears the command, result and timeout registers.
- Output values in reset and in IDLE:
  - cmd_ready=1.
  - All other outputs 0: Wr_En, Gate_En, ALU_En, WR_INC, busy, timeout_err, Addr, Wr_D, ALU_FUN, WR_DATA.
- Reset mid-operation aborts immediately. No further writes or FIFO pushes occur.
- On acceptance, cmd_fun, cmd_use_ops, cmd_op_a and cmd_op_b are latched. Input changes after acceptance are ignored.
- States: IDLE, WR_A, WR_B, ARM, EXEC, WAIT_RES, PUSH_LO, PUSH_HI.
- IDLE: on accept, go to WR_A if use_ops=1, else to ARM.
- WR_A: Wr_En=1, Addr=OPA_ADDR, Wr_D=op_a; go to WR_B.
- WR_B: Wr_En=1, Addr=OPB_ADDR, Wr_D=op_b; go to ARM.
- ARM: Gate_En=1 so the gated clock is running before the fire pulse; go to EXEC.
- EXEC: Gate_En=1, ALU_En=1, ALU_FUN=latched fun; go to WAIT_RES; clear the timeout counter.
- WAIT_RES: Gate_En=1; ALU_FUN is held; the counter increments each cycle.
  - If OUT_Valid=1: capture ALU_OUT into the result register and go to PUSH_LO.
  - Else if the counter reaches TIMEOUT: pulse timeout_err for one cycle and go to IDLE with no FIFO push.
  - OUT_Valid and timeout in the same cycle: OUT_Valid wins.
- PUSH_LO: WR_DATA=result[D_WIDTH-1:0]; WR_INC = !FIFO_FULL, combinational from FIFO_FULL.
  - Advance to PUSH_HI only in a cycle where WR_INC=1; otherwise stall indefinitely.
- PUSH_HI: same rules with result[2*D_WIDTH-1:D_WIDTH]; then go to IDLE.
- Gate_En is 0 in the push states: the ALU clock is off while the result drains.
- Latency, no stalls: accept at cycle 0; WR_A c1, WR_B c2, ARM c3, EXEC c4, first WAIT_RES c5.
  - With OUT_Valid at c5: PUSH_LO c6, PUSH_HI c7, cmd_ready=1 again at c8.
  - With use_ops=0, subtract 2 cycles.
- cmd_valid while busy is not accepted; the requester holds it.
- Exactly two WR_INC pulses per successful command; zero on timeout or reset abort.
- All state, counters and registered outputs update on the rising CLK edge only.

Test Plan:
1. Reset with RST=0 for 3 cycles, cmd_valid=1 -> no acceptance during reset; all outputs 0. After release, cmd_ready=1 and busy=0.
2. cmd_use_ops=1, A=0x12, B=0x34, fun=2, ALU returns 0x03A8 one cycle after ALU_En -> writes (addr0,0x12) at c1 and (addr1,0x34) at c2. ALU_En at c4 with ALU_FUN=2. WR_INC with 0xA8 at c6, then 0x03 at c7. cmd_ready high at c8.
3. cmd_use_ops=0, fun=0, ALU_OUT=0x00FF -> no Wr_En pulses; ALU_En at c2; FIFO receives 0xFF then 0x00.
4. FIFO_FULL=1 from PUSH_LO entry for 5 cycles -> WR_INC=0 and the state holds for 5 cycles. The 0xLO push occurs in the cycle FIFO_FULL drops; then the HI byte follows; exactly 2 pushes.
5. OUT_Valid never asserted, TIMEOUT=15 -> one timeout_err pulse after 15 WAIT_RES cycles; Gate_En drops; no WR_INC; IDLE next.
6. RST=0 asserted during PUSH_LO with FIFO full -> IDLE next cycle; WR_INC never pulses. A new command after reset completes normally.
